// File: rtl/pulse_window_counter_if.sv
// Bus between the pulse/tick sources and the window counter, plus the
// window history it publishes to the averager.
interface pulse_window_counter_if;
  logic       pulse_in;
  logic       sec_tick;
  logic       clear;
  logic [5:0] count1;
  logic [5:0] count2;
  logic [5:0] count3;
  logic [5:0] count4;
  logic [5:0] count_live;
  logic       window_done;
  logic       hist_full;

  modport master (
    output pulse_in, sec_tick, clear,
    input  count1, count2, count3, count4, count_live, window_done, hist_full
  );

  modport slave (
    input  pulse_in, sec_tick, clear,
    output count1, count2, count3, count4, count_live, window_done, hist_full
  );
endinterface

// File: rtl/pulse_window_counter.sv
// Counts debounced sensor pulses per WINDOW_SEC-second window and keeps
// the last four completed window counts for the downstream averager.
//
// state   | meaning
// EMPTY   | no window completed since reset/clear
// FILLING | 1..3 windows completed, average not yet valid
// FULL    | 4+ windows completed, hist_full asserted until reset/clear
module pulse_window_counter #(
  parameter int WINDOW_SEC     = 15,
  parameter int LOCKOUT_CYCLES = 1_000_000
) (
  input logic                    clk,
  input logic                    rst_n,
  pulse_window_counter_if.slave  bus
);
  localparam logic [7:0]  SEC_LAST  = 8'(WINDOW_SEC - 1);
  localparam logic [19:0] LOCK_LOAD = 20'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } fill_state_t;

  fill_state_t state, state_nxt;
  logic [2:0]  fill, fill_nxt;
  logic        full_nxt;

  logic        s1, s2, s3;
  logic        acc_q;
  logic [19:0] lock_cnt;
  logic [7:0]  sec_cnt;
  logic [5:0]  c1, c2, c3, c4, live;
  logic [5:0]  live_plus;
  logic        done_q, full_q;
  logic        pulse_edge, accept, win_end;

  assign pulse_edge = s2 & ~s3;
  assign accept     = pulse_edge & (lock_cnt == 20'd0);
  assign win_end    = bus.sec_tick & (sec_cnt == SEC_LAST);
  assign live_plus  = (acc_q && (live != 6'd63)) ? live + 6'd1 : live;

  // Sync chain, lockout and accept stage ignore clear so a clear can never
  // fabricate or swallow an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      acc_q    <= 1'b0;
      lock_cnt <= 20'd0;
    end else begin
      s1    <= bus.pulse_in;
      s2    <= s1;
      s3    <= s2;
      acc_q <= accept;
      if (accept)
        lock_cnt <= LOCK_LOAD;
      else if (lock_cnt != 20'd0)
        lock_cnt <= lock_cnt - 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c1      <= 6'd0;
      c2      <= 6'd0;
      c3      <= 6'd0;
      c4      <= 6'd0;
      live    <= 6'd0;
      sec_cnt <= 8'd0;
      done_q  <= 1'b0;
    end else if (bus.clear) begin
      c1      <= 6'd0;
      c2      <= 6'd0;
      c3      <= 6'd0;
      c4      <= 6'd0;
      live    <= 6'd0;
      sec_cnt <= 8'd0;
      done_q  <= 1'b0;
    end else if (win_end) begin
      c1      <= live_plus;
      c2      <= c1;
      c3      <= c2;
      c4      <= c3;
      live    <= 6'd0;
      sec_cnt <= 8'd0;
      done_q  <= 1'b1;
    end else begin
      live   <= live_plus;
      done_q <= 1'b0;
      if (bus.sec_tick)
        sec_cnt <= sec_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      fill   <= 3'd0;
      full_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      fill   <= fill_nxt;
      full_q <= full_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    if (bus.clear) begin
      state_nxt = EMPTY;
      fill_nxt  = 3'd0;
    end else if (win_end) begin
      case (state)
        EMPTY: begin
          state_nxt = FILLING;
          fill_nxt  = 3'd1;
        end
        FILLING: begin
          fill_nxt = fill + 3'd1;
          if (fill == 3'd3)
            state_nxt = FULL;
        end
        FULL: begin
          state_nxt = FULL;
          fill_nxt  = 3'd4;
        end
        default: begin
          state_nxt = EMPTY;
          fill_nxt  = 3'd0;
        end
      endcase
    end
  end

  // hist_full is registered alongside the state so the averager sees a clean flop.
  always_comb begin
    full_nxt = (state_nxt == FULL);
  end

  assign bus.count1      = c1;
  assign bus.count2      = c2;
  assign bus.count3      = c3;
  assign bus.count4      = c4;
  assign bus.count_live  = live;
  assign bus.window_done = done_q;
  assign bus.hist_full   = full_q;
endmodule

// File: tb/tb_pulse_window_counter.sv
// Randomised and directed bench for pulse_window_counter, checked against an
// event-level model (sampled rising edges, lockout spacing, window history).
module tb_pulse_window_counter;
  localparam int WS = 2;
  localparam int LK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pulse_window_counter_if bus ();

  pulse_window_counter #(.WINDOW_SEC(WS), .LOCKOUT_CYCLES(LK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [5:0] mh [4];
  logic [5:0] mlive;
  int         msec, mfill, cyc, last_acc;
  logic       mdone;
  bit         p_prev, has_acc;
  int         incq [$];

  function automatic logic [31:0] dut_vec();
    return {bus.count1, bus.count2, bus.count3, bus.count4, bus.count_live,
            bus.window_done, bus.hist_full};
  endfunction

  function automatic logic [31:0] ref_vec();
    return {mh[0], mh[1], mh[2], mh[3], mlive, mdone, (mfill == 4)};
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 4; i++) mh[i] = 6'd0;
    mlive = 6'd0;
    msec  = 0;
    mfill = 0;
    mdone = 1'b0;
  endtask

  // One clock: drive at negedge, advance the model at posedge, settle 1ns.
  task automatic step(input bit p, input bit t, input bit c);
    bit inc;
    @(negedge clk);
    bus.pulse_in = p;
    bus.sec_tick = t;
    bus.clear    = c;
    @(posedge clk);
    cyc++;
    inc = 1'b0;
    if (!rst_n) begin
      model_zero();
      p_prev  = 1'b0;
      has_acc = 1'b0;
      incq.delete();
    end else begin
      if (p && !p_prev && (!has_acc || (cyc - last_acc) > LK)) begin
        has_acc  = 1'b1;
        last_acc = cyc;
        incq.push_back(cyc + 3);
      end
      p_prev = p;
      if (incq.size() > 0 && incq[0] == cyc) begin
        void'(incq.pop_front());
        inc = 1'b1;
      end
      if (c) begin
        model_zero();
      end else if (t && msec == WS - 1) begin
        mh[3] = mh[2];
        mh[2] = mh[1];
        mh[1] = mh[0];
        mh[0] = (inc && mlive != 6'd63) ? mlive + 6'd1 : mlive;
        mlive = 6'd0;
        msec  = 0;
        if (mfill < 4) mfill++;
        mdone = 1'b1;
      end else begin
        mdone = 1'b0;
        if (t) msec++;
        if (inc && mlive != 6'd63) mlive = mlive + 6'd1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      vectors++;
      if (dut_vec() !== 32'd0 || ref_vec() !== 32'd0) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, dut_vec(), 32'd0);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        step(i == 0, 1'b0, 1'b0);
        vectors++;
        if (dut_vec() !== ref_vec()) begin
          miscompares++;
          $display("FAIL basic_trace cyc=%0d got=%h exp=%h", cyc, dut_vec(), ref_vec());
        end
      end
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    vectors++;
    if ({bus.count1, bus.count2, bus.count3, bus.count4, bus.window_done, bus.hist_full}
        !== {6'd3, 6'd0, 6'd0, 6'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_window got c1=%0d c2=%0d c3=%0d c4=%0d done=%b full=%b exp 3,0,0,0,1,0",
               bus.count1, bus.count2, bus.count3, bus.count4, bus.window_done, bus.hist_full);
    end
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus.window_done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_width got=%b exp=0", bus.window_done);
    end
  endtask

  task automatic test_lockout();
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(i == 0 || i == 2, 1'b0, 1'b0);
    vectors++;
    if (bus.count_live !== 6'd1 || ref_vec() !== dut_vec()) begin
      miscompares++;
      $display("FAIL lockout_2apart got=%0d exp=1", bus.count_live);
    end
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) step(i == 0 || i == 6, 1'b0, 1'b0);
    vectors++;
    if (bus.count_live !== 6'd2 || ref_vec() !== dut_vec()) begin
      miscompares++;
      $display("FAIL lockout_6apart got=%0d exp=2", bus.count_live);
    end
  endtask

  task automatic test_saturate();
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 70; k++)
      for (int i = 0; i < 7; i++) step(i == 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus.count_live !== 6'd63 || ref_vec() !== dut_vec()) begin
      miscompares++;
      $display("FAIL saturate_live got=%0d exp=63", bus.count_live);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    vectors++;
    if (bus.count1 !== 6'd63 || bus.count_live !== 6'd0) begin
      miscompares++;
      $display("FAIL saturate_c1 got c1=%0d live=%0d exp 63,0", bus.count1, bus.count_live);
    end
  endtask

  task automatic test_history();
    step(1'b0, 1'b0, 1'b1);
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 5 + w; k++)
        for (int i = 0; i < 7; i++) step(i == 0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      vectors++;
      if (dut_vec() !== ref_vec()) begin
        miscompares++;
        $display("FAIL history_w%0d got=%h exp=%h", w, dut_vec(), ref_vec());
      end
      if (w == 3) begin
        vectors++;
        if ({bus.count1, bus.count2, bus.count3, bus.count4, bus.hist_full}
            !== {6'd8, 6'd7, 6'd6, 6'd5, 1'b1}) begin
          miscompares++;
          $display("FAIL history_full got %0d,%0d,%0d,%0d full=%b exp 8,7,6,5 full=1",
                   bus.count1, bus.count2, bus.count3, bus.count4, bus.hist_full);
        end
      end
      if (w == 4) begin
        vectors++;
        if ({bus.count1, bus.count2, bus.count3, bus.count4, bus.hist_full}
            !== {6'd9, 6'd8, 6'd7, 6'd6, 1'b1}) begin
          miscompares++;
          $display("FAIL history_shift got %0d,%0d,%0d,%0d full=%b exp 9,8,7,6 full=1",
                   bus.count1, bus.count2, bus.count3, bus.count4, bus.hist_full);
        end
      end
    end
  endtask

  task automatic test_clear_at_end();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    vectors++;
    if (dut_vec() !== 32'd0 || ref_vec() !== 32'd0) begin
      miscompares++;
      $display("FAIL clear_at_end got=%h exp=%h", dut_vec(), 32'd0);
    end
    for (int i = 0; i < 7; i++) step(i == 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(i == 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    vectors++;
    if (dut_vec() !== 32'd0 || ref_vec() !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_window got=%h exp=%h", dut_vec(), 32'd0);
    end
  endtask

  task automatic test_edge_at_end();
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 7; i++) step(i == 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus.count_live !== 6'd4) begin
      miscompares++;
      $display("FAIL edge_at_end_pre got=%0d exp=4", bus.count_live);
    end
    step(1'b0, 1'b1, 1'b0);
    vectors++;
    if (bus.count1 !== 6'd5 || bus.count_live !== 6'd0 || dut_vec() !== ref_vec()) begin
      miscompares++;
      $display("FAIL edge_at_end got c1=%0d live=%0d exp 5,0", bus.count1, bus.count_live);
    end
  endtask

  task automatic test_reset_held_pulse();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus.count_live !== 6'd1 || dut_vec() !== ref_vec()) begin
      miscompares++;
      $display("FAIL reset_held_pulse got=%0d exp=1", bus.count_live);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit p = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) p = ~p;
      rst_n = ($urandom_range(399) != 0);
      step(p, $urandom_range(5) == 0, $urandom_range(149) == 0);
      vectors++;
      if (dut_vec() !== ref_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), ref_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    bus.pulse_in = 1'b0;
    bus.sec_tick = 1'b0;
    bus.clear    = 1'b0;
    cyc = 0;
    last_acc = 0;
    p_prev = 1'b0;
    has_acc = 1'b0;
    model_zero();
    test_reset();
    test_basic();
    test_lockout();
    test_saturate();
    test_history();
    test_clear_at_end();
    test_edge_at_end();
    test_reset_held_pulse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
